// File: rtl/wb_stage.sv
// wb_stage: writeback stage that commits register/LED CSR writes, counts retired instructions and halts.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   mem_*                      registered MEM latch fields of the committing instruction
//   rs1_no/rs2_no -> *_val     combinational register reads with write-first bypass
//   fwd_valid/fwd_regno/fwd_val registered copy of the last cycle's register write
//   led_out                    LED CSR contents
//   retired_cnt                retired instruction count (wraps)
//   halted/halt_pc             halt status and PC of the halt instruction
module wb_stage #(
    parameter int DBITS = 32,
    parameter int REGNOBITS = 5,
    parameter int CSRBITS = 12,
    parameter logic [CSRBITS-1:0] LED_CSR = 12'h7C0,
    parameter int LEDBITS = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_valid,
    input  logic                 mem_wr_reg,
    input  logic [REGNOBITS-1:0] mem_wregno,
    input  logic [DBITS-1:0]     mem_regval,
    input  logic                 mem_wr_csr,
    input  logic [CSRBITS-1:0]   mem_csrno,
    input  logic                 mem_halt,
    input  logic [DBITS-1:0]     mem_pc,
    input  logic [REGNOBITS-1:0] rs1_no,
    input  logic [REGNOBITS-1:0] rs2_no,
    output logic [DBITS-1:0]     rs1_val,
    output logic [DBITS-1:0]     rs2_val,
    output logic                 fwd_valid,
    output logic [REGNOBITS-1:0] fwd_regno,
    output logic [DBITS-1:0]     fwd_val,
    output logic [LEDBITS-1:0]   led_out,
    output logic [DBITS-1:0]     retired_cnt,
    output logic                 halted,
    output logic [DBITS-1:0]     halt_pc
);
    typedef enum logic {RUN, HALTED} state_t;
    state_t state;
    logic [DBITS-1:0] regs [0:2**REGNOBITS-1];
    logic commit, wr_reg, wr_led;
    logic unused_hi;
    assign unused_hi = ^mem_regval;
    assign commit = mem_valid & (state == RUN);
    // The halt instruction retires but its own register/CSR writes are dropped.
    assign wr_reg = commit & ~mem_halt & mem_wr_reg & (mem_wregno != '0);
    assign wr_led = commit & ~mem_halt & mem_wr_csr & (mem_csrno == LED_CSR);
    assign halted = (state == HALTED);
    always_comb begin
        rs1_val = (rs1_no == '0) ? '0 : (wr_reg && rs1_no == mem_wregno) ? mem_regval : regs[rs1_no];
        rs2_val = (rs2_no == '0) ? '0 : (wr_reg && rs2_no == mem_wregno) ? mem_regval : regs[rs2_no];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**REGNOBITS; i++) regs[i] <= '0;
            state <= RUN;
            led_out <= '0;
            retired_cnt <= '0;
            fwd_valid <= 1'b0;
            fwd_regno <= '0;
            fwd_val <= '0;
            halt_pc <= '0;
        end else begin
            fwd_valid <= wr_reg;
            if (wr_reg) begin
                regs[mem_wregno] <= mem_regval;
                fwd_regno <= mem_wregno;
                fwd_val <= mem_regval;
            end
            if (wr_led) led_out <= mem_regval[LEDBITS-1:0];
            if (commit) retired_cnt <= retired_cnt + 1'b1;
            if (commit && mem_halt) begin
                state <= HALTED;
                halt_pc <= mem_pc;
            end
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage.
module tb_wb_stage;
    logic clk = 1'b0;
    logic reset;
    logic mem_valid, mem_wr_reg, mem_wr_csr, mem_halt;
    logic [4:0] mem_wregno, rs1_no, rs2_no, fwd_regno;
    logic [31:0] mem_regval, mem_pc, rs1_val, rs2_val, fwd_val, retired_cnt, halt_pc;
    logic [11:0] mem_csrno;
    logic fwd_valid, halted;
    logic [9:0] led_out;
    // narrow instance used to reach the retired counter wrap quickly
    logic s_valid;
    logic [3:0] s_rs1, s_rs2, s_fv, s_cnt, s_hpc, s_led;
    logic [4:0] s_fr;
    logic s_fwd, s_halted;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_wr_reg(mem_wr_reg),
        .mem_wregno(mem_wregno), .mem_regval(mem_regval), .mem_wr_csr(mem_wr_csr),
        .mem_csrno(mem_csrno), .mem_halt(mem_halt), .mem_pc(mem_pc),
        .rs1_no(rs1_no), .rs2_no(rs2_no), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .fwd_valid(fwd_valid), .fwd_regno(fwd_regno), .fwd_val(fwd_val),
        .led_out(led_out), .retired_cnt(retired_cnt), .halted(halted), .halt_pc(halt_pc)
    );

    wb_stage #(.DBITS(4), .LEDBITS(4)) dut_s (
        .clk(clk), .reset(reset), .mem_valid(s_valid), .mem_wr_reg(1'b0),
        .mem_wregno(5'd0), .mem_regval(4'd0), .mem_wr_csr(1'b0),
        .mem_csrno(12'd0), .mem_halt(1'b0), .mem_pc(4'd0),
        .rs1_no(5'd0), .rs2_no(5'd0), .rs1_val(s_rs1), .rs2_val(s_rs2),
        .fwd_valid(s_fwd), .fwd_regno(s_fr), .fwd_val(s_fv),
        .led_out(s_led), .retired_cnt(s_cnt), .halted(s_halted), .halt_pc(s_hpc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        mem_valid = 0; mem_wr_reg = 0; mem_wr_csr = 0; mem_halt = 0;
        mem_wregno = 0; mem_regval = 0; mem_csrno = 0; mem_pc = 0;
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] v);
        idle();
        mem_valid = 1; mem_wr_reg = 1; mem_wregno = r; mem_regval = v;
    endtask

    initial begin
        reset = 1; s_valid = 0; rs1_no = 0; rs2_no = 0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 0;
        #1;
        chk("rst_cnt", retired_cnt, 0);
        chk("rst_halted", {31'd0, halted}, 0);
        chk("rst_fwd_valid", {31'd0, fwd_valid}, 0);
        chk("rst_led", {22'd0, led_out}, 0);
        chk("rst_halt_pc", halt_pc, 0);
        // x5 write with same-cycle bypass
        @(negedge clk) wr(5, 32'h0000_1234); rs1_no = 5;
        #1 chk("bypass_x5", rs1_val, 32'h1234);
        @(negedge clk) idle();
        #1;
        chk("read_x5", rs1_val, 32'h1234);
        chk("fwd_valid_x5", {31'd0, fwd_valid}, 1);
        chk("fwd_regno_x5", {27'd0, fwd_regno}, 5);
        chk("fwd_val_x5", fwd_val, 32'h1234);
        chk("cnt_1", retired_cnt, 1);
        @(negedge clk) wr(7, 32'hDEAD_BEEF); rs2_no = 7;
        #1 chk("bypass_x7", rs2_val, 32'hDEAD_BEEF);
        @(negedge clk) wr(0, 32'h55); rs1_no = 0;
        #1 chk("x0_bypass", rs1_val, 0);
        @(negedge clk) idle();
        #1;
        chk("x0_fwd_valid", {31'd0, fwd_valid}, 0);
        chk("x0_fwd_regno_hold", {27'd0, fwd_regno}, 7);
        chk("x0_fwd_val_hold", fwd_val, 32'hDEAD_BEEF);
        chk("read_x7", rs2_val, 32'hDEAD_BEEF);
        chk("x0_read", rs1_val, 0);
        chk("cnt_3", retired_cnt, 3);
        // LED CSR plus register write in one instruction
        @(negedge clk) wr(6, 32'hFFFF_F3A5); mem_wr_csr = 1; mem_csrno = 12'h7C0; rs1_no = 6;
        @(negedge clk) idle(); mem_valid = 1; mem_wr_csr = 1; mem_csrno = 12'h7C1; mem_regval = 32'h111;
        #1;
        chk("led_3a5", {22'd0, led_out}, 32'h3A5);
        chk("read_x6", rs1_val, 32'hFFFF_F3A5);
        chk("cnt_4", retired_cnt, 4);
        @(negedge clk) idle();
        #1;
        chk("led_other_csr", {22'd0, led_out}, 32'h3A5);
        chk("cnt_5", retired_cnt, 5);
        // back-to-back writes to the same register
        @(negedge clk) wr(8, 32'h1); rs1_no = 8;
        @(negedge clk) wr(8, 32'h2);
        #1 chk("b2b_bypass", rs1_val, 32'h2);
        @(negedge clk) idle();
        #1;
        chk("b2b_read", rs1_val, 32'h2);
        chk("cnt_7", retired_cnt, 7);
        // reset overrides a same-cycle commit
        @(negedge clk) reset = 1; wr(4, 32'h1); rs1_no = 4; rs2_no = 5;
        @(negedge clk) reset = 0; idle();
        #1;
        chk("rst_x4", rs1_val, 0);
        chk("rst_x5_cleared", rs2_val, 0);
        chk("rst2_cnt", retired_cnt, 0);
        chk("rst2_led", {22'd0, led_out}, 0);
        chk("rst2_fwd_valid", {31'd0, fwd_valid}, 0);
        // three writes, two bubbles, then halt
        @(negedge clk) wr(1, 32'd11);
        @(negedge clk) wr(2, 32'd22);
        @(negedge clk) wr(3, 32'd33);
        @(negedge clk) wr(9, 32'd99); mem_valid = 0;
        @(negedge clk) wr(9, 32'd99); mem_valid = 0; mem_wr_csr = 1; mem_csrno = 12'h7C0;
        #1 chk("bubble_fwd", {31'd0, fwd_valid}, 0);
        @(negedge clk) wr(3, 32'd9); mem_halt = 1; mem_pc = 32'h40; mem_wr_csr = 1; mem_csrno = 12'h7C0; mem_regval = 32'hFF;
        rs1_no = 3; rs2_no = 9;
        #1 chk("halt_no_bypass", rs1_val, 32'd33);
        @(negedge clk) wr(1, 32'd77); mem_halt = 1; mem_pc = 32'h80; rs1_no = 3;
        #1;
        chk("halt_cnt", retired_cnt, 4);
        chk("halted", {31'd0, halted}, 1);
        chk("halt_pc", halt_pc, 32'h40);
        chk("halt_x3", rs1_val, 32'd33);
        chk("bubble_x9", rs2_val, 0);
        chk("halt_led", {22'd0, led_out}, 0);
        chk("halt_fwd_valid", {31'd0, fwd_valid}, 0);
        rs1_no = 1;
        #1 chk("halted_no_bypass", rs1_val, 32'd11);
        @(negedge clk) idle();
        #1;
        chk("halted_x1", rs1_val, 32'd11);
        chk("halted_cnt", retired_cnt, 4);
        chk("halted_pc_hold", halt_pc, 32'h40);
        chk("halted_fwd", {31'd0, fwd_valid}, 0);
        // reset releases HALTED and commits resume
        @(negedge clk) reset = 1;
        @(negedge clk) reset = 0; wr(4, 32'd5); rs1_no = 4;
        @(negedge clk) idle();
        #1;
        chk("resume_x4", rs1_val, 32'd5);
        chk("resume_cnt", retired_cnt, 1);
        chk("resume_halted", {31'd0, halted}, 0);
        // counter wrap on the narrow instance
        @(negedge clk) s_valid = 1;
        repeat (15) @(negedge clk);
        #1 chk("wrap_max", {28'd0, s_cnt}, 32'hF);
        @(negedge clk);
        #1 chk("wrap_zero", {28'd0, s_cnt}, 0);
        @(negedge clk) s_valid = 0;
        #1 chk("wrap_one", {28'd0, s_cnt}, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final (writeback) pipeline stage, directly downstream of the memory stage.
- Consumes the registered MEM latch fields and commits results to the architectural integer register file and the LED CSR.
- Counts retired instructions and detects the halt instruction.
- Provides bypassed register read ports to decode and a registered forwarding bundle to decode/AGEX hazard logic.

Parameters:
- DBITS, 32, datapath/register width
- REGNOBITS, 5, register index width (2**REGNOBITS registers)
- CSRBITS, 12, CSR address width
- LED_CSR, 12'h7C0, CSR address mapped to the LED output register
- LEDBITS, 10, LED register width (low bits of written value)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mem_valid  in  1  MEM latch holds a real instruction (0 = bubble)
- mem_wr_reg  in  1  instruction writes the register file
- mem_wregno  in  REGNOBITS  destination register
- mem_regval  in  DBITS  value to write (register or CSR)
- mem_wr_csr  in  1  instruction writes a CSR
- mem_csrno  in  CSRBITS  CSR address
- mem_halt  in  1  instruction is the halt marker
- mem_pc  in  DBITS  PC of the instruction
- rs1_no, rs2_no  in  REGNOBITS each  decode read indices
- rs1_val, rs2_val  out  DBITS each  read data
- fwd_valid  out  1  registered: last cycle committed a register write
- fwd_regno  out  REGNOBITS  registered destination of that write
- fwd_val  out  DBITS  registered value of that write
- led_out  out  LEDBITS  LED CSR contents
- retired_cnt  out  DBITS  retired instruction count
- halted  out  1  core halted
- halt_pc  out  DBITS  PC of the halt instruction

Behaviour:
- Reset (sync, highest priority, overrides any same-cycle commit):
  - All registers become 0: regfile, led_out, retired_cnt, fwd_*, halted, halt_pc.
  - FSM enters RUN.
- FSM has two states, RUN and HALTED.
  - RUN -> HALTED on a posedge with mem_valid & mem_halt.
  - HALTED -> RUN only via reset.
- commit = mem_valid & state==RUN.
- Register write: at posedge when commit & mem_wr_reg & mem_wregno!=0, regfile[mem_wregno] <= mem_regval.
  - Register x0 always reads 0 and is never written.
- CSR write: at posedge when commit & mem_wr_csr & mem_csrno==LED_CSR, led_out <= mem_regval[LEDBITS-1:0].
  - Writes to other CSR addresses are ignored.
- A single instruction may assert both mem_wr_reg and mem_wr_csr; both commits occur in the same cycle.
- Halt instruction:
  - Counts as retired; halt_pc <= mem_pc.
  - Its mem_wr_reg / mem_wr_csr are ignored.
- retired_cnt: +1 per commit cycle; wraps modulo 2**DBITS; frozen in HALTED.
- Read ports are combinational with write-first bypass:
  - If the same cycle has a qualifying register write to rsN_no (nonzero), rsN_val = mem_regval.
  - Otherwise rsN_val = regfile[rsN_no].
  - rsN_no==0 gives 0.
- Forwarding bundle is registered (1-cycle latency):
  - fwd_valid <= qualifying register write this cycle, else 0.
  - fwd_regno / fwd_val are captured only when fwd_valid is set; otherwise they hold their last value.
- Bubbles (mem_valid=0) change nothing except clearing fwd_valid.
- In HALTED:
  - All commits are suppressed; fwd_valid stays 0.
  - Read ports still function.
  - halted=1, and outputs hold.
- Back-to-back writes to the same register: the later cycle's value wins; the read bypass always reflects the in-flight cycle.

Test Plan:
- Reset, then write x5=0x0000_1234 (valid, wr_reg) -> next cycle rs1_no=5 gives 0x1234; fwd_valid=1, fwd_regno=5, fwd_val=0x1234; retired_cnt=1.
- Same-cycle write x7=0xDEAD_BEEF with rs2_no=7 -> rs2_val=0xDEADBEEF in that cycle; a write targeting x0 -> rs1_no=0 reads 0, fwd_valid=0.
- CSR write csrno=0x7C0, val=0xFFFF_F3A5 -> led_out=10'h3A5; csrno=0x7C1 -> led_out unchanged.
- 3 valid instructions, 2 bubbles, then halt at PC 0x0000_0040 (with wr_reg x3=9) -> retired_cnt=4, halted=1, halt_pc=0x40, x3 unchanged; subsequent valid writes ignored and count stays 4.
- Reset asserted while mem_valid & mem_wr_reg write x4=1 -> x4 reads 0, retired_cnt=0, state RUN; a commit after reset deassertion works normally.
- Force retired_cnt to 0xFFFF_FFFF, then one commit -> retired_cnt=0.
